weight_commit_stage: RTL and testbench
======================================

// Module: weight_commit_stage
// PURPOSE
// - Registered weight store sitting between backPropper and neuron/backPropper in a learning neuron.
// - Accepts candidate weight vectors from backPropper and forms per-weight deltas against the stored weights.
// - Accumulates those deltas over a power-of-two mini-batch, then commits the averaged update serially.
// - Drives the stored weights back to both the neuron and backPropper.
// PARAMETERS
// - N_WEIGHTS   33  weight count (32 dendrite weights + bias)
// - WIDTH       32  bits per weight, two's complement
// - MAX_LOG2    4   largest batch exponent; max batch = 16
// PORTS
// - clock          in   1                  single clock, rising edge
// - reset          in   1                  asynchronous, active-high
// - wc_weightsNew  in   [N_WEIGHTS][WIDTH]  candidate weights from backPropper
// - wc_newValid    in   1                  wc_weightsNew holds a valid sample
// - wc_newReady    out  1                  stage can accept a sample this cycle
// - wc_batchLog2   in   3                  batch = 2^wc_batchLog2; values >MAX_LOG2 clamp to MAX_LOG2
// - wc_weights     out  [N_WEIGHTS][WIDTH]  committed weights, registered
// - wc_commitPulse out  1                  one-cycle strobe after a full commit
// - wc_busy        out  1                  high in APPLY and DONE
// BEHAVIOUR
// - Reset (async): wc_weights all 0, accumulators 0, count 0, index 0, state IDLE.
// - Reset: wc_newReady 0, wc_commitPulse 0, wc_busy 0; wc_newReady rises on first clock edge after release.
// - Reset mid-operation (any state, any index) discards partial accumulation/commit and restores the reset values.
// - Accept = wc_newValid && wc_newReady at a rising edge. wc_newReady=1 exactly in IDLE and ACCUM.
// - Per accept, for all i in parallel: delta_i = (wc_weightsNew[i] - wc_weights[i]) mod 2^WIDTH, read as signed.
// - Per accept: acc_i += sext(delta_i); acc width WIDTH+MAX_LOG2, no overflow is possible.
// - IDLE: on accept, latch k=min(wc_batchLog2,MAX_LOG2), add deltas, count=1.
// - IDLE: if 2^k==1, go APPLY; otherwise go ACCUM.
// - ACCUM: on accept, add deltas, count++. When count reaches 2^k, go APPLY with index=0.
// - ACCUM: wc_batchLog2 changes are ignored until the next batch.
// - APPLY: one weight per cycle, index 0..N_WEIGHTS-1.
// - APPLY: wc_weights[index] <= fix(wc_weights[index] + (acc_index >>> k)); acc_index <= 0.
// - APPLY: arithmetic shift right, rounds toward -inf. Sum is formed at WIDTH+MAX_LOG2+1 bits, then fix() applied.
// - APPLY: after index N_WEIGHTS-1, go DONE.
// - DONE: wc_commitPulse=1 for this single cycle, count=0, then go IDLE.
// - Latency (batch 1): accept at edge T; APPLY occupies T+1..T+33; pulse in cycle T+34; ready again at T+35.
// - wc_newValid held during APPLY/DONE is not consumed. It is accepted at the first IDLE edge.
// - wc_weights changes only in APPLY, so backPropper sees a stable set throughout ACCUM.
// CONFIGURATION
// - Macro WC_SATURATE_EN defined: fix() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
// - Macro WC_SATURATE_EN undefined: fix() truncates to WIDTH bits (modular wrap).
// TESTING
// - Reset assert then release -> all wc_weights=0, wc_newReady 0 then 1 one edge after release, pulse 0.
// - k=0, accept wc_weightsNew[5]=10 (others 0) -> ready low 34 cycles, wc_weights[5]=10, one pulse at T+34.
// - k=2, four accepts with weightsNew[0]=4,8,-4,12 -> sum 20 >>>2 = 5, so wc_weights[0]=5 after commit.
// - k=1, deltas -3 and 0 on weight 2 -> -3>>>1 = -2, so wc_weights[2]=-2 (floor rounding).
// - k=0, commit 0x7FFFFFF0 to w1, then weightsNew[1]=0x800000F0 (delta +0x100).
//   -> w1=0x7FFFFFFF with WC_SATURATE_EN; w1=0x800000F0 without.
// - Assert reset while APPLY is at index 10 -> all weights 0, IDLE. Valid held through APPLY is taken only after DONE.

Source files
------------

// File: rtl/weight_commit_stage.sv
// Registered weight store: accumulates per-weight deltas over a 2^k mini-batch, then commits
// the averaged update one weight per cycle. Optional macro WC_SATURATE_EN clamps committed weights.
module weight_commit_stage #(
  parameter int unsigned N_WEIGHTS = 33,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_LOG2  = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_WEIGHTS-1:0][WIDTH-1:0]     wc_weightsNew,
  input  logic                                wc_newValid,
  output logic                                wc_newReady,
  input  logic [2:0]                          wc_batchLog2,
  output logic [N_WEIGHTS-1:0][WIDTH-1:0]     wc_weights,
  output logic                                wc_commitPulse,
  output logic                                wc_busy
);

  localparam int unsigned AccW = WIDTH + MAX_LOG2;
  localparam int unsigned SumW = AccW + 1;
  localparam int unsigned IdxW = $clog2(N_WEIGHTS);
  localparam int unsigned CntW = MAX_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StApply, StDone} state_e;

  state_e                              state_q, state_d;
  logic                                started_q;
  logic [2:0]                          k_q, k_d, k_sel;
  logic [CntW-1:0]                     count_q, count_d, count_inc, batch_len;
  logic [IdxW-1:0]                     index_q, index_d;
  logic [N_WEIGHTS-1:0][AccW-1:0]      acc_q, acc_d;
  logic [N_WEIGHTS-1:0][WIDTH-1:0]     weights_q, weights_d;
  logic [N_WEIGHTS-1:0][WIDTH-1:0]     delta;
  logic [AccW-1:0]                     sel_acc;
  logic [WIDTH-1:0]                    sel_w;
  logic signed [AccW-1:0]              shifted;
  logic [SumW-1:0]                     sum;
  logic [WIDTH-1:0]                    fixed;
  logic                                accept;

  assign wc_newReady    = started_q && ((state_q == StIdle) || (state_q == StAccum));
  assign wc_busy        = (state_q == StApply) || (state_q == StDone);
  assign wc_commitPulse = (state_q == StDone);
  assign wc_weights     = weights_q;
  assign accept         = wc_newValid && wc_newReady;

  assign k_sel     = (wc_batchLog2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : wc_batchLog2;
  assign batch_len = CntW'(1) << k_q;
  assign count_inc = count_q + CntW'(1);

  // Delta is taken modulo 2^WIDTH before sign extension into the accumulator.
  always_comb begin
    for (int i = 0; i < int'(N_WEIGHTS); i++) begin
      delta[i] = wc_weightsNew[i] - weights_q[i];
    end
  end

  always_comb begin
    sel_acc = '0;
    sel_w   = '0;
    for (int i = 0; i < int'(N_WEIGHTS); i++) begin
      if (index_q == IdxW'(i)) begin
        sel_acc = acc_q[i];
        sel_w   = weights_q[i];
      end
    end
  end

  assign shifted = $signed(sel_acc) >>> k_q;
  assign sum     = {{(SumW - WIDTH){sel_w[WIDTH-1]}}, sel_w} + {shifted[AccW-1], shifted};

`ifdef WC_SATURATE_EN
  always_comb begin
    if ((&sum[SumW-1:WIDTH-1]) || !(|sum[SumW-1:WIDTH-1])) begin
      fixed = sum[WIDTH-1:0];
    end else if (sum[SumW-1]) begin
      fixed = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      fixed = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[SumW-1:WIDTH];
  assign fixed         = sum[WIDTH-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    count_d   = count_q;
    index_d   = index_q;
    acc_d     = acc_q;
    weights_d = weights_q;

    if (accept) begin
      for (int i = 0; i < int'(N_WEIGHTS); i++) begin
        acc_d[i] = acc_q[i] + {{MAX_LOG2{delta[i][WIDTH-1]}}, delta[i]};
      end
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          k_d     = k_sel;
          count_d = CntW'(1);
          index_d = '0;
          state_d = (k_sel == 3'd0) ? StApply : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          count_d = count_inc;
          if (count_inc == batch_len) begin
            index_d = '0;
            state_d = StApply;
          end
        end
      end
      StApply: begin
        for (int i = 0; i < int'(N_WEIGHTS); i++) begin
          if (index_q == IdxW'(i)) begin
            acc_d[i]     = '0;
            weights_d[i] = fixed;
          end
        end
        if (index_q == IdxW'(N_WEIGHTS - 1)) begin
          state_d = StDone;
        end else begin
          index_d = index_q + IdxW'(1);
        end
      end
      StDone: begin
        count_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      started_q <= 1'b0;
      k_q       <= '0;
      count_q   <= '0;
      index_q   <= '0;
      acc_q     <= '0;
      weights_q <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      k_q       <= k_d;
      count_q   <= count_d;
      index_q   <= index_d;
      acc_q     <= acc_d;
      weights_q <= weights_d;
    end
  end

endmodule

// File: tb/tb_weight_commit_stage.sv
// Directed bench for weight_commit_stage; expected values are hand-computed constants.
module tb_weight_commit_stage;

  localparam int unsigned NW = 33;
  localparam int unsigned W  = 32;

  logic                   clock;
  logic                   reset;
  logic [NW-1:0][W-1:0]   wc_weightsNew;
  logic                   wc_newValid;
  logic                   wc_newReady;
  logic [2:0]             wc_batchLog2;
  logic [NW-1:0][W-1:0]   wc_weights;
  logic                   wc_commitPulse;
  logic                   wc_busy;

  int n_checks = 0;
  int n_pass   = 0;

  weight_commit_stage dut (
    .clock          (clock),
    .reset          (reset),
    .wc_weightsNew  (wc_weightsNew),
    .wc_newValid    (wc_newValid),
    .wc_newReady    (wc_newReady),
    .wc_batchLog2   (wc_batchLog2),
    .wc_weights     (wc_weights),
    .wc_commitPulse (wc_commitPulse),
    .wc_busy        (wc_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clock);
    while (!wc_newReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!wc_newReady) check("ready_timeout", 64'(wc_newReady), 64'd1);
  endtask

  task automatic send(input logic [NW-1:0][W-1:0] v, input logic [2:0] lg);
    wait_ready();
    wc_weightsNew = v;
    wc_batchLog2  = lg;
    wc_newValid   = 1'b1;
    @(posedge clock);
    #1 wc_newValid = 1'b0;
  endtask

  task automatic wait_pulse();
    int n = 0;
    @(negedge clock);
    while (!wc_commitPulse && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!wc_commitPulse) check("pulse_timeout", 64'(wc_commitPulse), 64'd1);
  endtask

  initial begin
    logic [NW-1:0][W-1:0] v;
    int low, pulses, pulse_at;

    reset         = 1'b1;
    wc_newValid   = 1'b0;
    wc_batchLog2  = 3'd0;
    wc_weightsNew = '0;
    repeat (3) @(negedge clock);
    check("rst_weights", 64'(wc_weights == '0), 64'd1);
    check("rst_ready", 64'(wc_newReady), 64'd0);
    check("rst_pulse", 64'(wc_commitPulse), 64'd0);
    check("rst_busy", 64'(wc_busy), 64'd0);
    reset = 1'b0;
    #1 check("ready_after_release", 64'(wc_newReady), 64'd0);
    @(posedge clock);
    #1 check("ready_one_edge", 64'(wc_newReady), 64'd1);

    // Batch of one: latency and pulse placement.
    v = '0;
    v[5] = 32'd10;
    send(v, 3'd0);
    low = 0; pulses = 0; pulse_at = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (!wc_newReady) low++;
      if (wc_commitPulse) begin
        pulses++;
        pulse_at = c;
      end
    end
    check("k0_ready_low", 64'(low), 64'd34);
    check("k0_pulse_count", 64'(pulses), 64'd1);
    check("k0_pulse_cycle", 64'(pulse_at), 64'd34);
    check("k0_w5", 64'(wc_weights[5]), 64'd10);

    // Batch of four on weight 0: (4+8-4+12)>>>2 = 5.
    v[0] = 32'd4;  send(v, 3'd2);
    v[0] = 32'd8;  send(v, 3'd2);
    v[0] = -32'sd4; send(v, 3'd2);
    @(negedge clock);
    check("k2_not_busy", 64'(wc_busy), 64'd0);
    check("k2_w0_stable", 64'(wc_weights[0]), 64'd0);
    v[0] = 32'd12; send(v, 3'd2);
    wait_pulse();
    check("k2_w0", 64'(wc_weights[0]), 64'd5);
    check("k2_w5", 64'(wc_weights[5]), 64'd10);

    // Floor rounding, and batchLog2 ignored mid-batch.
    v[0] = 32'd5;
    v[2] = -32'sd3; send(v, 3'd1);
    @(negedge clock);
    check("k1_ready", 64'(wc_newReady), 64'd1);
    check("k1_busy", 64'(wc_busy), 64'd0);
    v[2] = 32'd0;   send(v, 3'd4);
    wait_pulse();
    check("k1_w2_floor", 64'(wc_weights[2]), 64'hFFFF_FFFE);

    // batchLog2=7 clamps to 16 samples: 16*16>>>4 = 16.
    v[2] = 32'hFFFF_FFFE;
    v[3] = 32'd16;
    for (int s = 0; s < 15; s++) send(v, 3'd7);
    @(negedge clock);
    check("clamp_not_busy", 64'(wc_busy), 64'd0);
    send(v, 3'd7);
    wait_pulse();
    check("clamp_w3", 64'(wc_weights[3]), 64'd16);
    check("clamp_w2", 64'(wc_weights[2]), 64'hFFFF_FFFE);

    // Overflow on commit.
    v[1] = 32'h7FFF_FFF0; send(v, 3'd0);
    wait_pulse();
    check("ovf_setup_w1", 64'(wc_weights[1]), 64'h7FFF_FFF0);
    v[1] = 32'h8000_00F0; send(v, 3'd0);
    wait_pulse();
`ifdef WC_SATURATE_EN
    check("ovf_w1", 64'(wc_weights[1]), 64'h7FFF_FFFF);
`else
    check("ovf_w1", 64'(wc_weights[1]), 64'h8000_00F0);
`endif

    // Reset while APPLY is at index 10.
    v[6] = 32'd123; send(v, 3'd0);
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_weights", 64'(wc_weights == '0), 64'd1);
    check("midrst_busy", 64'(wc_busy), 64'd0);
    check("midrst_ready", 64'(wc_newReady), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Valid held through APPLY/DONE is not consumed until IDLE.
    v = '0;
    v[4] = 32'd7;
    wait_ready();
    wc_weightsNew = v;
    wc_batchLog2  = 3'd0;
    wc_newValid   = 1'b1;
    @(posedge clock);
    #1 v[4] = 32'd9;
    wc_weightsNew = v;
    wait_pulse();
    check("hold_w4_first", 64'(wc_weights[4]), 64'd7);
    check("hold_ready_done", 64'(wc_newReady), 64'd0);
    @(negedge clock);
    check("hold_idle_ready", 64'(wc_newReady), 64'd1);
    check("hold_idle_busy", 64'(wc_busy), 64'd0);
    @(negedge clock);
    check("hold_taken", 64'(wc_busy), 64'd1);
    wc_newValid = 1'b0;
    wait_pulse();
    check("hold_w4_second", 64'(wc_weights[4]), 64'd9);
    check("hold_w6_zero", 64'(wc_weights[6]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
